micro_sequencer: RTL

//  Parametrised microprogram address sequencer: successor to the 4-bit sequencer slice, one full-width instance

---
 rtl/micro_seq_pkg.sv | 24 ++
 rtl/micro_seq_stack.sv | 87 ++++++++
 rtl/micro_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/micro_seq_pkg.sv
// micro_seq_pkg
//   Shared definitions for the microprogram address sequencer:
//   - source-select encodings for the next-address multiplexer
//   - the stack operation type and its decode from the fe_n/pup control pair
package micro_seq_pkg;

  localparam logic [1:0] SEL_PC  = 2'b00;
  localparam logic [1:0] SEL_AR  = 2'b01;
  localparam logic [1:0] SEL_STK = 2'b10;
  localparam logic [1:0] SEL_DIN = 2'b11;

  typedef enum logic [1:0] {
    STK_HOLD,
    STK_PUSH,
    STK_POP
  } stk_op_t;

  // fe_n is the active-low stack enable; pup chooses push over pop.
  function automatic stk_op_t decode_stk_op(input logic fe_n, input logic pup);
    if (fe_n) return STK_HOLD;
    return pup ? STK_PUSH : STK_POP;
  endfunction

endpackage

// File: rtl/micro_seq_stack.sv
// micro_seq_stack
//   Return-address LIFO for the microprogram sequencer.
//   Build option: MICRO_SEQ_STACK_GUARD_EN
//     defined   - push when full / pop when empty are ignored and stack_err
//                 latches high until reset.
//     undefined - push when full overwrites entry 0 and level restarts at 1
//                 (oldest return lost); pop when empty leaves level at 0;
//                 stack_err is tied low.
// Ports
//   clock, reset_n  clock and asynchronous active-low reset
//   op              stack operation for this cycle (hold / push / pop)
//   push_data       value written on push (current PC)
//   top             entry at level-1, zero when empty (pre-operation value)
//   full, empty     decoded from the level counter
//   stack_err       sticky overflow/underflow flag (guarded build only)
module micro_seq_stack
  import micro_seq_pkg::*;
#(
  parameter int AW    = 12,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  stk_op_t       op,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty,
  output logic          stack_err
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] entry [DEPTH];
  logic [LW-1:0] level;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] wr_idx;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  // When empty the index underflows, but top is forced to zero anyway.
  assign top_idx = IW'(level - LW'(1));
  assign top     = empty ? '0 : entry[top_idx];
  // A push while full lands in entry 0 (only reachable in the unguarded build).
  assign wr_idx  = full ? '0 : IW'(level);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
    end else begin
      case (op)
`ifdef MICRO_SEQ_STACK_GUARD_EN
        STK_PUSH: begin
          if (!full) begin
            entry[wr_idx] <= push_data;
            level         <= level + LW'(1);
          end
        end
`else
        STK_PUSH: begin
          entry[wr_idx] <= push_data;
          level         <= full ? LW'(1) : level + LW'(1);
        end
`endif
        STK_POP: begin
          if (!empty) level <= level - LW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef MICRO_SEQ_STACK_GUARD_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stack_err <= 1'b0;
    end else if ((op == STK_PUSH && full) || (op == STK_POP && empty)) begin
      stack_err <= 1'b1;
    end
  end
`else
  assign stack_err = 1'b0;
`endif

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer
//   Full-width microprogram address sequencer. Picks the next microaddress
//   from PC / address register / stack top / direct input, applies OR and
//   zero forcing, and registers PC = yout + cin. Holds a return stack
//   (micro_seq_stack) and a saturating loop counter.
//   Build option: MICRO_SEQ_STACK_GUARD_EN (see micro_seq_stack).
// Ports
//   clock, reset_n   clock and asynchronous active-low reset
//   din              direct address / branch target, also counter load value
//   rin, re_n        address register load value and active-low load enable
//   orin             OR-mask applied to the selected source
//   sel              source select (PC, AR, stack top, din)
//   zero_n           active-low force of yout to zero
//   cin              PC increment carry-in
//   fe_n, pup        stack enable (active-low) and push/pop select
//   cnt_ld, cnt_dec  loop counter load (priority) and decrement
//   yout, cout       next microaddress (combinational) and carry-out
//   full, empty      stack level flags
//   cnt_zero         loop counter is zero
//   stack_err        sticky stack overflow/underflow flag
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int AW    = 12,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [AW-1:0] din,
  input  logic [AW-1:0] rin,
  input  logic [AW-1:0] orin,
  input  logic [1:0]    sel,
  input  logic          zero_n,
  input  logic          cin,
  input  logic          re_n,
  input  logic          fe_n,
  input  logic          pup,
  input  logic          cnt_ld,
  input  logic          cnt_dec,
  output logic [AW-1:0] yout,
  output logic          cout,
  output logic          full,
  output logic          empty,
  output logic          cnt_zero,
  output logic          stack_err
);

  logic [AW-1:0] pc;
  logic [AW-1:0] ar;
  logic [AW-1:0] stk_top;
  logic [AW-1:0] mux;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_load;
  stk_op_t       stk_op;

  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - CW'(1);
  endfunction

  generate
    if (CW <= AW) begin : g_load_slice
      assign cnt_load = din[CW-1:0];
    end else begin : g_load_zext
      assign cnt_load = {{(CW - AW){1'b0}}, din};
    end
  endgenerate

  assign stk_op = decode_stk_op(fe_n, pup);

  micro_seq_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clock     (clock),
    .reset_n   (reset_n),
    .op        (stk_op),
    .push_data (pc),
    .top       (stk_top),
    .full      (full),
    .empty     (empty),
    .stack_err (stack_err)
  );

  always_comb begin
    mux = din;
    case (sel)
      SEL_PC:  mux = pc;
      SEL_AR:  mux = ar;
      SEL_STK: mux = stk_top;
      default: mux = din;
    endcase
  end

  assign yout     = zero_n ? (mux | orin) : '0;
  assign cout     = cin & (&yout);
  assign cnt_zero = (cnt == '0);

  // PC wraps naturally from all-ones to zero; cout flags that case.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc  <= '0;
      ar  <= '0;
      cnt <= '0;
    end else begin
      pc <= yout + AW'(cin);
      if (!re_n) ar <= rin;
      if (cnt_ld)       cnt <= cnt_load;
      else if (cnt_dec) cnt <= sat_dec(cnt);
    end
  end

endmodule
